// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   localparam int unsigned PC_STEP     = 4;
   localparam logic [31:0] INST_BUBBLE = 32'h0;
   localparam int unsigned STALL_CNT_W = 32;
   localparam int unsigned DROP_CNT_W  = 16;

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry capture of an acked instruction and its PC+4 while ID holds the pipe.
module if_fetch_hold_buf
   import if_fetch_pkg::*;
#(
   parameter int unsigned MEM_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ld_i,
   input  logic [MEM_W-1:0] inst_i,
   input  logic [MEM_W-1:0] pc4_i,
   output logic [MEM_W-1:0] inst_o,
   output logic [MEM_W-1:0] pc4_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inst_o <= '0;
         pc4_o  <= '0;
      end else if (ld_i) begin
         inst_o <= inst_i;
         pc4_o  <= pc4_i;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC, req/ack imem handshake, hold buffer and stale-response drop.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/drop counters.
module if_fetch_unit
   import if_fetch_pkg::*;
#(
   parameter int unsigned      MEM_W    = 32,
   parameter logic [MEM_W-1:0] RESET_PC = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   hd_i,
   input  logic                   branch_i,
   input  logic [MEM_W-1:0]       branch_addr_i,
   output logic                   mem_req_o,
   output logic [MEM_W-1:0]       mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [MEM_W-1:0]       mem_data_i,
   output logic [MEM_W-1:0]       inst_o,
   output logic [MEM_W-1:0]       pc_plus4_o,
   output logic                   valid_o,
   output logic                   stall_o,
   output logic                   flush_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

   fetch_state_e     state_q, state_d;
   logic [MEM_W-1:0] pc_q, pc_d, pend_q, pend_d;
   logic [MEM_W-1:0] br_tgt, pc_inc, buf_inst, buf_pc4;
   logic [MEM_W-1:0] inst, pc4;
   logic             buf_ld, req, valid, stall;

   assign br_tgt = branch_addr_i & ~MEM_W'(3);
   assign pc_inc = pc_q + MEM_W'(PC_STEP);

   if_fetch_hold_buf #(.MEM_W(MEM_W)) u_hold_buf (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ld_i   (buf_ld),
      .inst_i (mem_data_i),
      .pc4_i  (pc_inc),
      .inst_o (buf_inst),
      .pc4_o  (buf_pc4)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      buf_ld  = 1'b0;
      req     = 1'b1;
      valid   = 1'b0;
      inst    = MEM_W'(INST_BUBBLE);
      pc4     = '0;
      stall   = 1'b0;
      case (state_q)
         FETCH: begin
            if (branch_i) begin
               // an ack arriving with the redirect belongs to the wrong path
               stall = ~mem_ack_i;
               if (mem_ack_i) begin
                  pc_d = br_tgt;
               end else begin
                  pend_d  = br_tgt;
                  state_d = DROP;
               end
            end else if (mem_ack_i) begin
               if (hd_i) begin
                  buf_ld  = 1'b1;
                  state_d = HOLD;
               end else begin
                  valid = 1'b1;
                  inst  = mem_data_i;
                  pc4   = pc_inc;
                  pc_d  = pc_inc;
               end
            end else begin
               stall = 1'b1;
            end
         end
         HOLD: begin
            req   = 1'b0;
            valid = 1'b1;
            inst  = buf_inst;
            pc4   = buf_pc4;
            if (branch_i) begin
               pc_d    = br_tgt;
               state_d = FETCH;
            end else if (!hd_i) begin
               pc_d    = buf_pc4;
               state_d = FETCH;
            end
         end
         DROP: begin
            // keep the stale request alive until its ack; the latest target wins
            stall = 1'b1;
            if (branch_i) pend_d = br_tgt;
            if (mem_ack_i) begin
               pc_d    = branch_i ? br_tgt : pend_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   assign mem_req_o  = req & ~rst_i;
   assign mem_addr_o = rst_i ? '0 : pc_q;
   assign inst_o     = rst_i ? '0 : inst;
   assign pc_plus4_o = rst_i ? '0 : pc4;
   assign valid_o    = valid & ~rst_i;
   assign stall_o    = stall & ~rst_i;
   assign flush_o    = branch_i & ~rst_i;

`ifdef FETCH_PERF_CNT_EN
   logic                   drop_ack;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [DROP_CNT_W-1:0]  drop_cnt_q;

   assign drop_ack = mem_ack_i & (((state_q == FETCH) & branch_i) | (state_q == DROP));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
         if (drop_ack && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, reset pulse, then random traffic vs a flag-based model.
module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        hd_i = 1'b0;
   logic        branch_i = 1'b1;
   logic [31:0] branch_addr_i = '0;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   logic        mem_req_o, valid_o, stall_o, flush_o;
   logic [31:0] mem_addr_o, inst_o, pc_plus4_o, stall_cnt_o;
   logic [15:0] drop_cnt_o;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk_i = ~clk_i;

   if_fetch_unit #(.MEM_W(32), .RESET_PC(32'h40)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .hd_i(hd_i), .branch_i(branch_i),
      .branch_addr_i(branch_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .inst_o(inst_o),
      .pc_plus4_o(pc_plus4_o), .valid_o(valid_o), .stall_o(stall_o), .flush_o(flush_o),
      .stall_cnt_o(stall_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   typedef struct {
      logic        hd, br, ack;
      logic [31:0] baddr, data;
      logic        e_req, chk_out, e_valid, e_stall, e_flush;
      logic [31:0] e_addr, e_inst, e_pc4;
   } vec_t;

   vec_t tbl[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input int hd, input int br, input logic [31:0] ba, input int ack,
                               input logic [31:0] d, input int rq, input logic [31:0] ad,
                               input int ck, input int vl, input logic [31:0] in,
                               input logic [31:0] p4, input int st, input int fl);
      vec_t v;
      v.hd = (hd != 0); v.br = (br != 0); v.baddr = ba; v.ack = (ack != 0); v.data = d;
      v.e_req = (rq != 0); v.e_addr = ad; v.chk_out = (ck != 0); v.e_valid = (vl != 0);
      v.e_inst = in; v.e_pc4 = p4; v.e_stall = (st != 0); v.e_flush = (fl != 0);
      return v;
   endfunction

   // entered at posedge+1, drives inputs, checks at negedge, returns at next posedge+1
   task automatic run_vec(input vec_t v, input string tag);
      hd_i = v.hd; branch_i = v.br; branch_addr_i = v.baddr;
      mem_ack_i = v.ack; mem_data_i = v.data;
      @(negedge clk_i);
      chk({tag, ".req"}, 32'(mem_req_o), 32'(v.e_req));
      if (v.e_req) chk({tag, ".addr"}, mem_addr_o, v.e_addr);
      chk({tag, ".flush"}, 32'(flush_o), 32'(v.e_flush));
      if (v.chk_out) begin
         chk({tag, ".valid"}, 32'(valid_o), 32'(v.e_valid));
         chk({tag, ".inst"}, inst_o, v.e_inst);
         chk({tag, ".pc4"}, pc_plus4_o, v.e_pc4);
         chk({tag, ".stall"}, 32'(stall_o), 32'(v.e_stall));
      end
      @(posedge clk_i); #1;
   endtask

   // reference model state: plain flags rather than a state machine
   logic [31:0] m_pc, m_hinst, m_hpc4, m_tgt;
   logic        m_held, m_drop;
   int          m_stalls, m_drops, lat;

   initial begin
      logic [31:0] tgt, e_addr;
      logic        e_req, hd, br, ack;
      logic [31:0] ba, dat;

      //         hd br baddr         ack data           req addr          ck vl inst           pc4           st fl
      tbl[0]  = mk(0, 1, 32'h3,        1, 32'hDEAD_BEEF, 1, 32'h40,        1, 0, 0,             0,             0, 1);
      tbl[1]  = mk(0, 0, 0,            1, 32'hC0DE_0000, 1, 32'h0,         1, 1, 32'hC0DE_0000, 32'h4,         0, 0);
      tbl[2]  = mk(0, 0, 0,            1, 32'hC0DE_0004, 1, 32'h4,         1, 1, 32'hC0DE_0004, 32'h8,         0, 0);
      tbl[3]  = mk(0, 0, 0,            1, 32'hC0DE_0008, 1, 32'h8,         1, 1, 32'hC0DE_0008, 32'hC,         0, 0);
      tbl[4]  = mk(0, 0, 0,            1, 32'hC0DE_000C, 1, 32'hC,         1, 1, 32'hC0DE_000C, 32'h10,        0, 0);
      tbl[5]  = mk(0, 0, 0,            0, 0,             1, 32'h10,        1, 0, 0,             0,             1, 0);
      tbl[6]  = mk(0, 0, 0,            0, 0,             1, 32'h10,        1, 0, 0,             0,             1, 0);
      tbl[7]  = mk(0, 0, 0,            1, 32'hC0DE_0010, 1, 32'h10,        1, 1, 32'hC0DE_0010, 32'h14,        0, 0);
      tbl[8]  = mk(1, 0, 0,            1, 32'hC0DE_0014, 1, 32'h14,        0, 0, 0,             0,             0, 0);
      tbl[9]  = mk(1, 0, 0,            0, 0,             0, 0,             1, 1, 32'hC0DE_0014, 32'h18,        0, 0);
      tbl[10] = mk(1, 0, 0,            0, 0,             0, 0,             1, 1, 32'hC0DE_0014, 32'h18,        0, 0);
      tbl[11] = mk(0, 0, 0,            0, 0,             0, 0,             1, 1, 32'hC0DE_0014, 32'h18,        0, 0);
      tbl[12] = mk(0, 0, 0,            0, 0,             1, 32'h18,        1, 0, 0,             0,             1, 0);
      tbl[13] = mk(0, 1, 32'h100,      0, 0,             1, 32'h18,        1, 0, 0,             0,             1, 1);
      tbl[14] = mk(0, 0, 0,            0, 0,             1, 32'h18,        1, 0, 0,             0,             1, 0);
      tbl[15] = mk(0, 0, 0,            1, 32'hBAD0_0018, 1, 32'h18,        1, 0, 0,             0,             1, 0);
      tbl[16] = mk(0, 0, 0,            1, 32'hC0DE_0100, 1, 32'h100,       1, 1, 32'hC0DE_0100, 32'h104,       0, 0);
      tbl[17] = mk(0, 1, 32'h180,      0, 0,             1, 32'h104,       1, 0, 0,             0,             1, 1);
      tbl[18] = mk(0, 1, 32'h200,      1, 32'hBAD0_0104, 1, 32'h104,       1, 0, 0,             0,             1, 1);
      tbl[19] = mk(0, 0, 0,            1, 32'hC0DE_0200, 1, 32'h200,       1, 1, 32'hC0DE_0200, 32'h204,       0, 0);
      tbl[20] = mk(1, 0, 0,            1, 32'hC0DE_0204, 1, 32'h204,       0, 0, 0,             0,             0, 0);
      tbl[21] = mk(1, 1, 32'h300,      0, 0,             0, 0,             1, 1, 32'hC0DE_0204, 32'h208,       0, 1);
      tbl[22] = mk(0, 0, 0,            1, 32'hC0DE_0300, 1, 32'h300,       1, 1, 32'hC0DE_0300, 32'h304,       0, 0);
      tbl[23] = mk(0, 1, 32'hFFFF_FFFE, 1, 32'hBAD0_0304, 1, 32'h304,      1, 0, 0,             0,             0, 1);
      tbl[24] = mk(0, 0, 0,            1, 32'hC0DE_FFFC, 1, 32'hFFFF_FFFC, 1, 1, 32'hC0DE_FFFC, 32'h0,         0, 0);
      tbl[25] = mk(0, 0, 0,            0, 0,             1, 32'h0,         1, 0, 0,             0,             1, 0);

      // reset state: outputs forced low even with branch_i driven high
      #2;
      chk("rst.req", 32'(mem_req_o), 32'h0);
      chk("rst.flush", 32'(flush_o), 32'h0);
      chk("rst.stall", 32'(stall_o), 32'h0);
      chk("rst.addr", mem_addr_o, 32'h0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b0; branch_i = 1'b0;

      for (int i = 0; i < 26; i++) run_vec(tbl[i], $sformatf("row%0d", i));

      hd_i = 1'b0; branch_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
      chk("cnt.addr", mem_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.stall", stall_cnt_o, 32'd9);
      chk("cnt.drop", 32'(drop_cnt_o), 32'd4);
`else
      chk("cnt.stall", stall_cnt_o, 32'd0);
      chk("cnt.drop", 32'(drop_cnt_o), 32'd0);
`endif
      @(posedge clk_i); #1;

      run_vec(mk(0, 0, 0, 1, 32'hC0DE_1000, 1, 32'h0, 1, 1, 32'hC0DE_1000, 32'h4, 0, 0), "seq0");
      run_vec(mk(0, 0, 0, 1, 32'hC0DE_1004, 1, 32'h4, 1, 1, 32'hC0DE_1004, 32'h8, 0, 0), "seq4");
      run_vec(mk(0, 0, 0, 1, 32'hC0DE_1008, 1, 32'h8, 1, 1, 32'hC0DE_1008, 32'hC, 0, 0), "seq8");
      run_vec(mk(0, 0, 0, 0, 0,             1, 32'hC, 1, 0, 0,             0,     1, 0), "seqC");

      // reset mid-request at C: everything drops to zero at once
      rst_i = 1'b1; branch_i = 1'b1; hd_i = 1'b1; mem_ack_i = 1'b0;
      #1;
      chk("midrst.req", 32'(mem_req_o), 32'h0);
      chk("midrst.addr", mem_addr_o, 32'h0);
      chk("midrst.inst", inst_o, 32'h0);
      chk("midrst.pc4", pc_plus4_o, 32'h0);
      chk("midrst.valid", 32'(valid_o), 32'h0);
      chk("midrst.stall", 32'(stall_o), 32'h0);
      chk("midrst.flush", 32'(flush_o), 32'h0);
      chk("midrst.stall_cnt", stall_cnt_o, 32'h0);
      chk("midrst.drop_cnt", 32'(drop_cnt_o), 32'h0);
      @(posedge clk_i); #1;
      chk("midrst.req2", 32'(mem_req_o), 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; branch_i = 1'b0; hd_i = 1'b0;

      // random phase, model restarts from RESET_PC
      m_pc = 32'h40; m_held = 1'b0; m_drop = 1'b0; m_tgt = '0;
      m_hinst = '0; m_hpc4 = '0; m_stalls = 0; m_drops = 0; lat = -1;
      for (int c = 0; c < 1500; c++) begin
         hd  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 7) == 0);
         ba  = $urandom;
         dat = $urandom;
         ack = 1'b0;
         e_req = !m_held;
         e_addr = m_pc;
         if (e_req) begin
            if (lat < 0) lat = $urandom_range(0, 3);
            if (lat == 0) begin ack = 1'b1; lat = -1; end
            else lat--;
         end
         hd_i = hd; branch_i = br; branch_addr_i = ba; mem_ack_i = ack; mem_data_i = dat;
         @(negedge clk_i);
         chk($sformatf("rnd%0d.req", c), 32'(mem_req_o), 32'(e_req));
         if (e_req) chk($sformatf("rnd%0d.addr", c), mem_addr_o, e_addr);
         chk($sformatf("rnd%0d.flush", c), 32'(flush_o), 32'(br));
         if (m_held) begin
            chk($sformatf("rnd%0d.valid", c), 32'(valid_o), 32'h1);
            chk($sformatf("rnd%0d.inst", c), inst_o, m_hinst);
            chk($sformatf("rnd%0d.pc4", c), pc_plus4_o, m_hpc4);
            chk($sformatf("rnd%0d.stall", c), 32'(stall_o), 32'h0);
         end else if (m_drop || !ack) begin
            chk($sformatf("rnd%0d.valid", c), 32'(valid_o), 32'h0);
            chk($sformatf("rnd%0d.stall", c), 32'(stall_o), 32'h1);
         end else if (br) begin
            chk($sformatf("rnd%0d.stall", c), 32'(stall_o), 32'h0);
         end else if (!hd) begin
            chk($sformatf("rnd%0d.valid", c), 32'(valid_o), 32'h1);
            chk($sformatf("rnd%0d.inst", c), inst_o, dat);
            chk($sformatf("rnd%0d.pc4", c), pc_plus4_o, m_pc + 32'd4);
            chk($sformatf("rnd%0d.stall", c), 32'(stall_o), 32'h0);
         end
         if (valid_o === 1'b0) begin
            chk($sformatf("rnd%0d.bubble_inst", c), inst_o, 32'h0);
            chk($sformatf("rnd%0d.bubble_pc4", c), pc_plus4_o, 32'h0);
         end

         tgt = {ba[31:2], 2'b00};
         if (!m_held && (m_drop || !ack)) m_stalls++;
         if (m_held) begin
            if (br) begin m_pc = tgt; m_held = 1'b0; end
            else if (!hd) begin m_pc = m_hpc4; m_held = 1'b0; end
         end else if (m_drop) begin
            if (br) m_tgt = tgt;
            if (ack) begin m_drops++; m_pc = m_tgt; m_drop = 1'b0; end
         end else if (br) begin
            if (ack) begin m_drops++; m_pc = tgt; end
            else begin m_drop = 1'b1; m_tgt = tgt; end
         end else if (ack) begin
            if (hd) begin m_held = 1'b1; m_hinst = dat; m_hpc4 = m_pc + 32'd4; end
            else m_pc = m_pc + 32'd4;
         end
         @(posedge clk_i); #1;
      end

      hd_i = 1'b0; branch_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
`ifdef FETCH_PERF_CNT_EN
      chk("rnd.stall_cnt", stall_cnt_o, 32'(m_stalls));
      chk("rnd.drop_cnt", 32'(drop_cnt_o), 32'(m_drops));
`else
      chk("rnd.stall_cnt", stall_cnt_o, 32'h0);
      chk("rnd.drop_cnt", 32'(drop_cnt_o), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that produces the instruction and PC+4 consumed by the IF/ID pipeline register.
- Owns the PC and a req/ack instruction-memory handshake.
- Generates the stall and flush controls that the IF/ID register obeys.
- Absorbs hazard holds with a one-entry hold buffer and discards stale responses after a branch redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_W, 32, instruction/address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
hd_i  in  1  hazard-detect hold from ID; pipeline frozen this cycle
branch_i  in  1  taken-branch redirect from ID
branch_addr_i  in  32  redirect target; bits [1:0] ignored and forced to 0
mem_req_o  out  1  instruction-memory request, level
mem_addr_o  out  32  request address
mem_ack_i  in  1  response valid; may arrive in the same cycle as the request
mem_data_i  in  32  instruction word, valid with mem_ack_i
inst_o  out  32  instruction to IF/ID; 0 when valid_o=0
pc_plus4_o  out  32  PC+4 of inst_o to IF/ID; 0 when valid_o=0
valid_o  out  1  inst_o is a real instruction
stall_o  out  1  IF/ID must hold (fetch not ready)
flush_o  out  1  IF/ID must load a bubble (equals branch_i)

Behaviour:
- Clock is clk_i. Reset is rst_i, asynchronous, active-high.
- Reset values: state=FETCH, pc_r=RESET_PC, pend_pc=0, buffers=0.
- While rst_i is high, all outputs are forced to 0, including mem_req_o.

Handshake rule:
- Once mem_req_o rises, it and mem_addr_o stay stable until the cycle mem_ack_i=1 (inclusive).
- Requests are never aborted.

FETCH state:
- mem_req_o=1, mem_addr_o=pc_r.
- Branch: branch_i=1 has priority over hd_i and ack. flush_o=1.
  - If ack is present, discard the data, set pc_r<=branch_addr_i, and stay in FETCH.
  - Otherwise set pend_pc<=branch_addr_i and go to DROP.
- Ack, no hold (ack & ~hd_i): inst_o=mem_data_i, pc_plus4_o=pc_r+4, valid_o=1, stall_o=0. pc_r<=pc_r+4.
- Ack with hold (ack & hd_i): capture buf_inst<=mem_data_i and buf_pc4<=pc_r+4, go to HOLD. Outputs this cycle are don't-care; IF/ID is frozen by hd_i.
- No ack: valid_o=0, stall_o=1.

HOLD state:
- mem_req_o=0. inst_o=buf_inst, pc_plus4_o=buf_pc4, valid_o=1, stall_o=0.
- branch_i: flush_o=1, pc_r<=branch_addr_i, go to FETCH.
- ~hd_i: pc_r<=buf_pc4, go to FETCH. The IF/ID register latches the buffered instruction on this edge.
- hd_i: stay in HOLD indefinitely.

DROP state:
- mem_req_o=1 with the stale address pc_r. valid_o=0, stall_o=1.
- branch_i: pend_pc<=branch_addr_i (latest target wins), flush_o=1.
- Ack: pc_r<=pend_pc (or branch_addr_i if branch_i is high the same cycle), go to FETCH.

Arithmetic and boundary rules:
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request drops the outstanding request. After reset, the memory must not return an ack for it.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds stall_cnt_o (32 bits) and drop_cnt_o (16 bits), both reset to 0 and both saturating.
  - stall_cnt_o increments each cycle stall_o=1.
  - drop_cnt_o increments on each discarded ack: ack in FETCH with branch_i, and every ack in DROP.
- Undefined: both ports present and tied to 0; no counter flops.

Decomposition:
- Package if_fetch_pkg holds:
  - state enum {FETCH, HOLD, DROP}
  - PC_STEP=4
  - INST_BUBBLE=32'h0
  - counter widths
- One natural sub-module: if_fetch_hold_buf, the inst/pc4 capture register with load enable.
- The FSM and PC live in the top level.

Test Plan:
- Zero-wait memory (ack same cycle), no hazards -> addresses 0,4,8,C on consecutive cycles; valid_o=1 every cycle; stall_o=0.
- 3-cycle memory latency -> stall_o=1 for 2 cycles, then valid_o=1 with pc_plus4_o=4; mem_addr_o held at 0 throughout.
- Ack at PC=8 while hd_i=1 for 3 cycles -> HOLD entered, mem_req_o=0; when hd_i falls, inst_o=buffered word, pc_plus4_o=C; next request to C.
- branch_i to 32'h100 while a request to 4 is pending -> flush_o=1; DROP keeps address 4 until ack; that ack is discarded; next request to 100.
- Second branch to 200 during DROP, with ack in the same cycle -> next fetch at 200; drop_cnt_o=1 with FETCH_PERF_CNT_EN.
- rst_i pulsed mid-WAIT at PC=C with RESET_PC=40 -> all outputs 0 immediately; first request after release at 40.
